instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;
   timeunit 1ns;
   timeprecision 1ps;

   localparam int IMEM_SIZE_DEFAULT = 1024;
   localparam int INSTR_BYTES       = 4;

   typedef logic [63:0] addr_t;
   typedef logic [31:0] instr_t;

   typedef struct packed {
      instr_t instr;
      addr_t  pc;
   } fetch_entry_t;

   typedef enum logic {FETCH, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: power-of-two ring with wrap-bit pointers and a
// synchronous flush that overrides any push or pop in the same cycle.
module fetch_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic
) (
   input  logic clk,
   input  logic reset,
   input  logic i_flush,
   input  logic i_push,
   input  T     i_push_data,
   input  logic i_pop,
   output T     o_pop_data,
   output logic o_empty,
   output logic o_full
);
   timeunit 1ns;
   timeprecision 1ps;

   localparam int AW = $clog2(DEPTH);

   T             r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_do_push;
   logic         w_do_pop;

   // A push into a full buffer is legal only when the head leaves this cycle.
   assign w_do_push = i_push && (!o_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty;

   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; emptiness is tracked by the
   // pointers alone, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
   end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential pc, redirect handling, sticky fault, buffered output.
// Optional macro IFETCH_BOUNDS_CHECK_EN faults on fetches beyond IMEM_SIZE.
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter addr_t RESET_PC   = 64'h0,
   parameter int    IMEM_SIZE  = IMEM_SIZE_DEFAULT,
   parameter int    FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_address,
   input  logic [31:0] imem_instruction,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        fault
);
   timeunit 1ns;
   timeprecision 1ps;

   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("instr_fetch: RESET_PC must be 4-byte aligned");
   end
   if (IMEM_SIZE <= 4 || (IMEM_SIZE & (IMEM_SIZE - 1)) != 0) begin : g_bad_imem_size
      $error("instr_fetch: IMEM_SIZE must be a power of two greater than 4");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instr_fetch: FIFO_DEPTH must be a power of two of at least 2");
   end

   fetch_state_t r_state;
   addr_t        r_pc;
   logic         r_fault;
   logic         w_empty;
   logic         w_full;
   logic         w_pop;
   logic         w_push;
   logic         w_flush;
   logic         w_bounds_fault;
   fetch_entry_t w_push_entry;
   fetch_entry_t w_head;

`ifdef IFETCH_BOUNDS_CHECK_EN
   assign w_bounds_fault = (r_pc >= 64'(IMEM_SIZE - 3));
`else
   assign w_bounds_fault = 1'b0;
`endif

   // A misaligned redirect faults without flushing so buffered work can drain.
   assign w_flush = (r_state == FETCH) && redirect_valid && (redirect_target[1:0] == 2'b00);
   assign w_pop   = !w_empty && out_ready;
   assign w_push  = (r_state == FETCH) && !redirect_valid && !w_bounds_fault &&
                    (!w_full || w_pop);

   assign w_push_entry = '{instr: imem_instruction, pc: r_pc};
   assign imem_address = r_pc;
   assign out_valid    = !w_empty;
   assign out_instr    = w_head.instr;
   assign out_pc       = w_head.pc;
   assign fault        = r_fault;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
      end else if (r_state == FETCH) begin
         if (redirect_valid) begin
            if (redirect_target[1:0] != 2'b00) begin
               r_fault <= 1'b1;
               r_state <= HALT;
            end else begin
               r_pc <= redirect_target;
            end
`ifdef IFETCH_BOUNDS_CHECK_EN
         end else if (w_bounds_fault) begin
            r_fault <= 1'b1;
            r_state <= HALT;
            $error("instr_fetch: pc %h out of range at %0t ns", r_pc, $time);
`endif
         end else if (w_push) begin
            r_pc <= r_pc + 64'(INSTR_BYTES);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (w_flush),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .o_pop_data  (w_head),
      .o_empty     (w_empty),
      .o_full      (w_full)
   );
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect, fault, reset.
module tb_instr_fetch;
   timeunit 1ns;
   timeprecision 1ps;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] imem_address;
   logic [31:0] imem_instruction;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // ROM: word at byte address a is 0xC0DE0000 | (a >> 2) inside 1 KiB, X outside.
   assign imem_instruction = (imem_address < 64'd1024) ?
                             (32'hC0DE_0000 | 32'(imem_address[9:2])) : 32'hxxxx_xxxx;

   instr_fetch dut (
      .clk              (clk),
      .reset            (reset),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instr        (out_instr),
      .out_pc           (out_pc),
      .fault            (fault)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset           = 1'b1;
      out_ready       = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = '0;

      // Reset state and straight-line streaming
      tick(); tick();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_fault", 64'(fault), 64'd0);
      check("rst_addr", imem_address, 64'd0);
      reset = 1'b0;
      tick();
      check("s0_valid", 64'(out_valid), 64'd1);
      check("s0_pc", out_pc, 64'd0);
      check("s0_instr", 64'(out_instr), 64'hC0DE_0000);
      check("s0_addr", imem_address, 64'd4);
      tick();
      check("s1_pc", out_pc, 64'd4);
      check("s1_instr", 64'(out_instr), 64'hC0DE_0001);
      tick();
      check("s2_pc", out_pc, 64'd8);
      check("s2_instr", 64'(out_instr), 64'hC0DE_0002);
      tick();
      check("s3_pc", out_pc, 64'd12);
      check("s3_instr", 64'(out_instr), 64'hC0DE_0003);

      // Backpressure from a fresh reset; async reset observed mid-cycle
      out_ready = 1'b0;
      reset     = 1'b1;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      tick();
      reset = 1'b0;
      tick();
      check("bp1_addr", imem_address, 64'd4);
      check("bp1_pc", out_pc, 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_addr", imem_address, 64'd8);
         check("bp_pc", out_pc, 64'd0);
         check("bp_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      tick();
      check("rel0_pc", out_pc, 64'd4);
      check("rel0_addr", imem_address, 64'd12);
      tick();
      check("rel1_pc", out_pc, 64'd8);
      check("rel1_valid", 64'(out_valid), 64'd1);

      // Async reset with the buffer full
      out_ready = 1'b0;
      tick(); tick();
      check("full_valid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      #1;
      check("frst_valid", 64'(out_valid), 64'd0);
      check("frst_fault", 64'(fault), 64'd0);
      check("frst_addr", imem_address, 64'd0);
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;

      // Redirect while streaming
      tick();
      check("rs_pc", out_pc, 64'd0);
      redirect_valid  = 1'b1;
      redirect_target = 64'h40;
      tick();
      check("rd_valid", 64'(out_valid), 64'd0);
      check("rd_addr", imem_address, 64'h40);
      redirect_valid = 1'b0;
      tick();
      check("rd1_valid", 64'(out_valid), 64'd1);
      check("rd1_pc", out_pc, 64'h40);
      check("rd1_instr", 64'(out_instr), 64'hC0DE_0010);

      // Misaligned redirect: fault, drain, later redirect ignored
      out_ready = 1'b0;
      tick();
      redirect_valid  = 1'b1;
      redirect_target = 64'h42;
      tick();
      check("mis_fault", 64'(fault), 64'd1);
      check("mis_valid", 64'(out_valid), 64'd1);
      check("mis_pc", out_pc, 64'h40);
      check("mis_addr", imem_address, 64'h48);
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      tick();
      check("drain_pc", out_pc, 64'h44);
      check("drain_addr", imem_address, 64'h48);
      tick();
      check("drain_empty", 64'(out_valid), 64'd0);
      redirect_valid  = 1'b1;
      redirect_target = 64'h80;
      tick();
      check("halt_valid", 64'(out_valid), 64'd0);
      check("halt_addr", imem_address, 64'h48);
      check("halt_fault", 64'(fault), 64'd1);

      // End of ROM
      reset           = 1'b1;
      redirect_target = 64'd1020;
      tick();
      reset = 1'b0;
      tick();
      check("end_valid", 64'(out_valid), 64'd0);
      check("end_addr", imem_address, 64'd1020);
      check("end_fault", 64'(fault), 64'd0);
      redirect_valid = 1'b0;
      tick();
      check("last_pc", out_pc, 64'd1020);
      check("last_instr", 64'(out_instr), 64'hC0DE_00FF);
      tick();
`ifdef IFETCH_BOUNDS_CHECK_EN
      check("oob_fault", 64'(fault), 64'd1);
      check("oob_valid", 64'(out_valid), 64'd0);
      check("oob_addr", imem_address, 64'd1024);
`else
      check("oob_fault", 64'(fault), 64'd0);
      check("oob_valid", 64'(out_valid), 64'd1);
      check("oob_pc", out_pc, 64'd1024);

      // pc increment wraps modulo 2^64
      redirect_valid  = 1'b1;
      redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      check("wrap_addr0", imem_address, 64'hFFFF_FFFF_FFFF_FFFC);
      redirect_valid = 1'b0;
      tick();
      check("wrap_addr1", imem_address, 64'd0);
      check("wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
